alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit ALU.
- Takes a WIDTH-bit operand pair and a 4-bit opcode through a valid/ready handshake.
- Registers the result, an upper product half and a 4-bit status register (sreg).
- Adds XOR, single-bit shifts, a flag-only compare and an iterative shift-add multiplier; sits between the operand/register-file stage and writeback.

Parameters:
- WIDTH, 8, operand/result width (>=4).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL opcode decodes as NOP.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  opcode/operands valid
- in_ready  out  1  block can accept (high in IDLE)
- op  in  4  operation select
- operand_a  in  WIDTH  operand A
- operand_b  in  WIDTH  operand B
- out_valid  out  1  one-cycle pulse: result/sreg updated
- result  out  WIDTH  result register
- result_hi  out  WIDTH  upper product half (MUL only, else held)
- sreg  out  4  {V,N,C,Z}: bit0 Z, bit1 C, bit2 N, bit3 V
- busy  out  1  multiply in progress (= ~in_ready)

Behaviour:
- Reset: result, result_hi, sreg = 0; out_valid = 0; FSM = IDLE; in_ready = 1. rst has priority over everything, including an active multiply, which is aborted with no out_valid.
- Accept = in_valid & in_ready at a rising edge.
- Single-cycle ops:
  - result/sreg update on the accept edge.
  - out_valid is high for exactly the following cycle (latency 1).
  - Back-to-back accepts allowed every cycle.
- Opcodes:
  - 0 NOP: sreg = 0, result held.
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 ADC: A+B+C.
  - 4 SBC: A-B-C.
  - 5 CMP: flags of A-B; result not written.
  - 6 OR.
  - 7 AND.
  - 8 XOR.
  - 9 MUL.
  - 10 SHL: result = A<<1, C = A[W-1].
  - 11 SHR: logical, C = A[0].
  - 12 ASR: sign kept, C = A[0].
  - 13-15: NOP.
  - NOP also pulses out_valid.
- Arithmetic uses a (WIDTH+1)-bit internal sum.
  - C is carry for ADD/ADC and unsigned borrow for SUB/SBC/CMP (C=1 iff A < B+Cin unsigned).
  - C in ADC/SBC is the registered sreg[1] value before the edge.
- Flags:
  - Z = (result==0).
  - N = result[W-1].
  - ADD/ADC: V = A,B same sign and result sign differs.
  - SUB/SBC/CMP: V = A,B signs differ and result sign differs from A.
  - Logic ops: C=0, V=0, Z/N from result.
  - Shifts: V=0.
  - Signed A<B after CMP is N^V.
- MUL (unsigned, WIDTH x WIDTH -> 2*WIDTH):
  - FSM IDLE -> BUSY on accept. Latch A, B; clear accumulator and counter.
  - BUSY: one shift-add step per cycle; counter counts 0..WIDTH-1.
  - On the step where counter = WIDTH-1: write result = product[W-1:0] and result_hi = product[2W-1:W].
  - Flags: Z = (product==0), C = (result_hi != 0), N = 0, V = 0.
  - Then return to IDLE; out_valid is high the next cycle.
  - Total latency WIDTH cycles from the accept edge.
  - in_ready = 0 throughout BUSY; in_valid during BUSY is ignored (upstream must hold).
  - in_ready returns high in the same cycle out_valid pulses.
  - result, result_hi and sreg stay stable during BUSY.
- Outputs hold their last values when idle. out_valid is never high two cycles for one accept.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_NOP..OP_ASR.
  - sreg bit indices SREG_Z=0, SREG_C=1, SREG_N=2, SREG_V=3.
  - FSM state encoding IDLE/BUSY.
- One sub-module: alu_seq_mul. It is the iterative shift-add multiplier with start/done, parametrised by WIDTH. The top keeps the combinational datapath, flag logic, handshake and output registers.

Test Plan (WIDTH=8):
1. ADD 0x7F,0x01 -> next cycle out_valid=1, result 0x80, sreg 4'b1100; following cycle out_valid=0.
2. ADD 0xFF,0x01 -> result 0x00, sreg 4'b0011; then ADC 0x00,0x00 -> result 0x01, sreg 4'b0000.
3. SUB 0x00,0x01 -> result 0xFF, sreg 4'b0110; then SBC 0x05,0x02 -> result 0x02 (5-2-1), sreg 4'b0000.
4. CMP 0x80,0x01 after result 0x02 -> result stays 0x02, sreg 4'b1000 (V=1, N^V=1 => signed less-than).
5. MUL 0xFF,0xFF -> in_ready low 8 cycles; in_valid with ADD during busy ignored; out_valid 8 cycles after accept; result 0x01, result_hi 0xFE, sreg 4'b0010; MUL 0x00,0x37 -> sreg 4'b0001.
6. rst high 3 cycles into MUL -> next cycle result=result_hi=0, sreg=0, in_ready=1, no out_valid pulse ever for the aborted op.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, status bit indices and FSM states for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_ADC = 4'd3;
    localparam logic [3:0] OP_SBC = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_ASR = 4'd12;

    localparam int SREG_Z = 0;
    localparam int SREG_C = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between issue stage and alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       sreg;
    logic             busy;

    modport master (
        output in_valid, op, operand_a, operand_b,
        input  in_ready, out_valid, result, result_hi, sreg, busy
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b,
        output in_ready, out_valid, result, result_hi, sreg, busy
    );

endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative unsigned shift-add multiplier, one step per cycle
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH:0]   step_sum;

    // Partial product: add A into the upper half when the current multiplier bit is set;
    // the shifted {sum, lo} pair is the accumulator after this step.
    always_comb begin
        step_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
        product  = {step_sum, lo_q[WIDTH-1:1]};
        done     = running && (cnt == CW'(WIDTH - 1));
    end

    // Latch operands on start, then shift the accumulator right once per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            a_q     <= a;
            hi_q    <= '0;
            lo_q    <= b;
        end else if (running) begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
            cnt  <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with status register and iterative multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);

    state_t             state;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [3:0]         sreg_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         op;
    logic               accept;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   nx_res;
    logic [WIDTH-1:0]   flag_val;
    logic [3:0]         nx_sreg;
    logic               nx_c;
    logic               nx_v;
    logic               wr_res;
    logic               is_nop;
    logic               is_mul;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign a      = bus.operand_a;
    assign b      = bus.operand_b;
    assign op     = bus.op;
    assign accept = bus.in_valid && (state == IDLE);

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.sreg      = sreg_q;

    // Shared (WIDTH+1)-bit adder/subtractor; carry-in is the stored C flag for ADC/SBC only.
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && sreg_q[SREG_C]};
        sub_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) && sreg_q[SREG_C]};
    end

    // Opcode decode: next result, flag source value and C/V for single-cycle ops.
    always_comb begin
        nx_res   = result_q;
        flag_val = '0;
        nx_c     = 1'b0;
        nx_v     = 1'b0;
        wr_res   = 1'b1;
        is_nop   = 1'b0;
        is_mul   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                nx_res = add_s[WIDTH-1:0];
                nx_c   = add_s[WIDTH];
                nx_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                nx_res = sub_s[WIDTH-1:0];
                nx_c   = sub_s[WIDTH];
                nx_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  nx_res = a | b;
            OP_AND: nx_res = a & b;
            OP_XOR: nx_res = a ^ b;
            OP_SHL: begin
                nx_res = {a[WIDTH-2:0], 1'b0};
                nx_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                nx_res = {1'b0, a[WIDTH-1:1]};
                nx_c   = a[0];
            end
            OP_ASR: begin
                nx_res = {a[WIDTH-1], a[WIDTH-1:1]};
                nx_c   = a[0];
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    is_mul = 1'b1;
                end else begin
                    is_nop = 1'b1;
                end
            end
            default: is_nop = 1'b1;
        endcase

        // CMP computes flags from the difference but leaves the result register alone.
        flag_val = nx_res;
        if (op == OP_CMP) begin
            wr_res = 1'b0;
        end
        if (is_nop || is_mul) begin
            nx_res = result_q;
            wr_res = 1'b0;
        end

        nx_sreg          = '0;
        nx_sreg[SREG_Z]  = (flag_val == '0);
        nx_sreg[SREG_N]  = flag_val[WIDTH-1];
        nx_sreg[SREG_C]  = nx_c;
        nx_sreg[SREG_V]  = nx_v;
        if (is_nop) begin
            nx_sreg = '0;
        end
    end

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Handshake FSM and output registers; reset aborts an in-flight multiply silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            sreg_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= BUSY;
                        end else begin
                            if (wr_res) begin
                                result_q <= nx_res;
                            end
                            sreg_q      <= nx_sreg;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        result_q         <= mul_product[WIDTH-1:0];
                        result_hi_q      <= mul_product[2*WIDTH-1:WIDTH];
                        sreg_q           <= '0;
                        sreg_q[SREG_Z]   <= (mul_product == '0);
                        sreg_q[SREG_C]   <= (mul_product[2*WIDTH-1:WIDTH] != '0);
                        out_valid_q      <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic model
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] exp_res = 8'h00;
    logic [7:0] exp_hi  = 8'h00;
    logic [3:0] exp_sreg = 4'h0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_res"},  32'(bus.result),    32'(exp_res));
        check({tag, "_hi"},   32'(bus.result_hi), 32'(exp_hi));
        check({tag, "_sreg"}, 32'(bus.sreg),      32'(exp_sreg));
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: plain integer arithmetic; overflow judged by signed range.
    task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        int ai, bi, sa, sb, cin, s, ss, fr, p;
        bit c, v, nop, wr;
        ai = int'(a); bi = int'(b);
        sa = to_signed8(ai); sb = to_signed8(bi);
        cin = 0; c = 0; v = 0; nop = 0; wr = 1; fr = 0;
        case (o)
            OP_ADD, OP_ADC: begin
                if (o == OP_ADC) cin = int'(exp_sreg[1]);
                s  = ai + bi + cin;
                ss = sa + sb + cin;
                fr = s % 256;
                c  = (s > 255);
                v  = (ss > 127) || (ss < -128);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                if (o == OP_SBC) cin = int'(exp_sreg[1]);
                s  = ai - bi - cin;
                ss = sa - sb - cin;
                fr = (s + 512) % 256;
                c  = (s < 0);
                v  = (ss > 127) || (ss < -128);
                if (o == OP_CMP) wr = 0;
            end
            OP_OR:  fr = ai | bi;
            OP_AND: fr = ai & bi;
            OP_XOR: fr = ai ^ bi;
            OP_SHL: begin fr = (ai * 2) % 256; c = (ai >= 128); end
            OP_SHR: begin fr = ai / 2; c = (ai % 2) == 1; end
            OP_ASR: begin fr = ai / 2 + ((ai >= 128) ? 128 : 0); c = (ai % 2) == 1; end
            OP_MUL: begin
                p = ai * bi;
                exp_res  = 8'(p % 256);
                exp_hi   = 8'(p / 256);
                exp_sreg = {1'b0, 1'b0, (p / 256) != 0, p == 0};
                return;
            end
            default: nop = 1;
        endcase
        if (nop) begin
            exp_sreg = 4'h0;
        end else begin
            if (wr) exp_res = 8'(fr);
            exp_sreg = {v, fr >= 128, c, fr == 0};
        end
    endtask

    // Issue one op at the current (post-edge) time; returns #1 after out_valid appears.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        int n;
        logic [7:0] hold_res, hold_hi;
        logic [3:0] hold_sreg;
        hold_res = bus.result; hold_hi = bus.result_hi; hold_sreg = bus.sreg;
        bus.in_valid = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        model(o, a, b);
        if (o == OP_MUL) begin
            n = 0;
            check("mul_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("mul_busy", 32'(bus.busy), 32'd1);
            // Offer an ADD while busy; it must be ignored.
            bus.in_valid = 1'b1; bus.op = OP_ADD;
            bus.operand_a = 8'($urandom); bus.operand_b = 8'($urandom);
            while (!bus.out_valid && n < 20) begin
                if (bus.result !== hold_res || bus.result_hi !== hold_hi || bus.sreg !== hold_sreg)
                    check("mul_stable", {bus.result, bus.result_hi, bus.sreg},
                          {hold_res, hold_hi, hold_sreg});
                @(posedge clk); #1;
                n++;
            end
            bus.in_valid = 1'b0;
            check("mul_latency", 32'(n), 32'd8);
            check("mul_ready_back", 32'(bus.in_ready), 32'd1);
        end else begin
            check("op_out_valid", 32'(bus.out_valid), 32'd1);
        end
        check_outputs("op");
    endtask

    initial begin
        int seen;
        logic [3:0] o;
        bus.in_valid = 1'b0; bus.op = 4'h0; bus.operand_a = 8'h00; bus.operand_b = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check_outputs("rst");

        issue(OP_ADD, 8'h7F, 8'h01);
        check("t1_res", 32'(bus.result), 32'h80);
        check("t1_sreg", 32'(bus.sreg), 32'b1100);
        @(posedge clk); #1;
        check("t1_pulse_end", 32'(bus.out_valid), 32'd0);

        issue(OP_ADD, 8'hFF, 8'h01);
        check("t2_sreg", 32'(bus.sreg), 32'b0011);
        issue(OP_ADC, 8'h00, 8'h00);
        check("t2_adc", {bus.result, bus.sreg}, {8'h01, 4'b0000});
        issue(OP_SUB, 8'h00, 8'h01);
        check("t3_sub", {bus.result, bus.sreg}, {8'hFF, 4'b0110});
        issue(OP_SBC, 8'h05, 8'h02);
        check("t3_sbc", {bus.result, bus.sreg}, {8'h02, 4'b0000});
        issue(OP_CMP, 8'h80, 8'h01);
        check("t4_cmp", {bus.result, bus.sreg}, {8'h02, 4'b1000});

        issue(OP_MUL, 8'hFF, 8'hFF);
        check("t5_mul", {bus.result, bus.result_hi, bus.sreg}, {8'h01, 8'hFE, 4'b0010});
        @(posedge clk); #1;
        check("t5_pulse_end", 32'(bus.out_valid), 32'd0);
        issue(OP_MUL, 8'h00, 8'h37);
        check("t5_mul_zero", 32'(bus.sreg), 32'b0001);

        // Random back-to-back traffic over all 16 opcodes, with occasional gaps.
        for (int i = 0; i < 400; i++) begin
            o = 4'($urandom_range(0, 15));
            issue(o, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                check("gap_out_valid", 32'(bus.out_valid), 32'd0);
            end
        end

        // Reset three cycles into a multiply aborts it without a result pulse.
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.operand_a = 8'hA5; bus.operand_b = 8'h3C;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_res = 8'h00; exp_hi = 8'h00; exp_sreg = 4'h0;
        check_outputs("t6_abort");
        check("t6_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("t6_no_pulse", 32'(seen), 32'd0);
        issue(OP_XOR, 8'h5A, 8'hFF);
        check("t6_after", 32'(bus.result), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
